// File: rtl/ace_snoop_responder_pkg.sv
// Shared types and snoop-encoding helpers for the ACE snoop responder.
package ace_snoop_responder_pkg;

    // Action the cache applies to the line when the lookup hits.
    typedef enum logic [1:0] {
        KEEP  = 2'd0,
        SHARE = 2'd1,
        CLEAN = 2'd2,
        INVAL = 2'd3
    } snoop_op_t;

    // CR response bits, MSB first in the same order as the port.
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } cr_resp_t;

    // How a snoop is handled before any cache access happens.
    typedef enum logic [1:0] {
        CLASS_LOOKUP   = 2'd0,
        CLASS_DVM      = 2'd1,
        CLASS_RESERVED = 2'd2
    } snoop_class_t;

    localparam logic [3:0] ACSNOOP_READ_ONCE              = 4'b0000;
    localparam logic [3:0] ACSNOOP_READ_SHARED            = 4'b0001;
    localparam logic [3:0] ACSNOOP_READ_CLEAN             = 4'b0010;
    localparam logic [3:0] ACSNOOP_READ_NOT_SHARED_DIRTY  = 4'b0011;
    localparam logic [3:0] ACSNOOP_READ_UNIQUE            = 4'b0111;
    localparam logic [3:0] ACSNOOP_CLEAN_SHARED           = 4'b1000;
    localparam logic [3:0] ACSNOOP_CLEAN_INVALID          = 4'b1001;
    localparam logic [3:0] ACSNOOP_MAKE_INVALID           = 4'b1101;
    localparam logic [3:0] ACSNOOP_DVM_COMPLETE           = 4'b1110;
    localparam logic [3:0] ACSNOOP_DVM_MESSAGE            = 4'b1111;

    // Sort an incoming snoop into lookup, DVM or reserved handling.
    function automatic snoop_class_t classify_snoop(input logic [3:0] snoop);
        snoop_class_t cls;
        case (snoop)
            ACSNOOP_READ_ONCE,
            ACSNOOP_READ_SHARED,
            ACSNOOP_READ_CLEAN,
            ACSNOOP_READ_NOT_SHARED_DIRTY,
            ACSNOOP_READ_UNIQUE,
            ACSNOOP_CLEAN_SHARED,
            ACSNOOP_CLEAN_INVALID,
            ACSNOOP_MAKE_INVALID:  cls = CLASS_LOOKUP;
            ACSNOOP_DVM_COMPLETE,
            ACSNOOP_DVM_MESSAGE:   cls = CLASS_DVM;
            default:               cls = CLASS_RESERVED;
        endcase
        return cls;
    endfunction

    // Line-state action requested from the cache for a lookup snoop.
    function automatic snoop_op_t lookup_op(input logic [3:0] snoop);
        snoop_op_t op;
        case (snoop)
            ACSNOOP_READ_SHARED,
            ACSNOOP_READ_CLEAN,
            ACSNOOP_READ_NOT_SHARED_DIRTY:  op = SHARE;
            ACSNOOP_CLEAN_SHARED:           op = CLEAN;
            ACSNOOP_READ_UNIQUE,
            ACSNOOP_CLEAN_INVALID,
            ACSNOOP_MAKE_INVALID:           op = INVAL;
            default:                        op = KEEP;
        endcase
        return op;
    endfunction

    // Response for a lookup given the line state before the op; a miss answers all-zero.
    function automatic cr_resp_t lookup_resp(input logic [3:0] snoop,
                                             input logic       hit,
                                             input logic       dirty,
                                             input logic       shared);
        cr_resp_t resp;
        resp = '0;
        if (hit) begin
            resp.was_unique = ~shared;
            case (snoop)
                ACSNOOP_READ_ONCE: begin
                    resp.data_transfer = 1'b1;
                    resp.is_shared     = 1'b1;
                end
                ACSNOOP_READ_SHARED,
                ACSNOOP_READ_CLEAN,
                ACSNOOP_READ_NOT_SHARED_DIRTY: begin
                    resp.data_transfer = 1'b1;
                    resp.is_shared     = 1'b1;
                    resp.pass_dirty    = dirty;
                end
                ACSNOOP_READ_UNIQUE: begin
                    resp.data_transfer = 1'b1;
                    resp.pass_dirty    = dirty;
                end
                ACSNOOP_CLEAN_SHARED: begin
                    resp.data_transfer = dirty;
                    resp.pass_dirty    = dirty;
                    resp.is_shared     = 1'b1;
                end
                ACSNOOP_CLEAN_INVALID: begin
                    resp.data_transfer = dirty;
                    resp.pass_dirty    = dirty;
                end
                default: begin
                    resp.data_transfer = 1'b0;
                end
            endcase
        end
        return resp;
    endfunction

endpackage

// File: rtl/ace_snoop_responder.sv
// ACE snoop slave: accepts one AC snoop, runs one cache lookup, answers on CR and streams the line on CD.
module ace_snoop_responder
    import ace_snoop_responder_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    input  logic [2:0]           ac_prot_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 lkp_req_o,
    input  logic                 lkp_gnt_i,
    output logic [AddrWidth-1:0] lkp_addr_o,
    output logic [1:0]           lkp_op_o,
    input  logic                 lkp_valid_i,
    input  logic                 lkp_hit_i,
    input  logic                 lkp_dirty_i,
    input  logic                 lkp_shared_i,
    input  logic [LineWidth-1:0] lkp_data_i
);

    localparam int unsigned NrBeats    = LineWidth / DataWidth;
    localparam int unsigned BeatWidth  = (NrBeats > 1) ? $clog2(NrBeats) : 1;
    localparam int unsigned OffsetBits = $clog2(LineWidth / 8);
    localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(NrBeats - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q;
    logic [3:0]            snoop_q;
    logic [2:0]            prot_unused_q;
    logic [LineWidth-1:0]  line_q;
    logic [BeatWidth-1:0]  beat_q;
    logic                  cr_done_q;
    logic                  cd_done_q;

    logic                  cr_hs;
    logic                  cd_hs;
    logic                  cr_done_now;
    logic                  cd_done_now;
    logic [BeatWidth-1:0]  beat_next;
    logic [DataWidth-1:0]  next_beat_data;
    cr_resp_t              wait_resp;

    // Handshake decode and the CD beat mux that selects the next beat from the held line.
    always_comb begin
        cr_hs          = cr_valid_o & cr_ready_i;
        cd_hs          = cd_valid_o & cd_ready_i;
        cr_done_now    = cr_done_q | cr_hs;
        cd_done_now    = cd_done_q | (cd_hs & cd_last_o);
        beat_next      = beat_q + 1'b1;
        next_beat_data = line_q[int'(beat_next) * DataWidth +: DataWidth];
        wait_resp      = lookup_resp(snoop_q, lkp_hit_i, lkp_dirty_i, lkp_shared_i);
    end

    // Snoop FSM with every channel output registered so it holds steady under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            snoop_q       <= '0;
            prot_unused_q <= '0;
            line_q        <= '0;
            beat_q        <= '0;
            cr_done_q     <= 1'b0;
            cd_done_q     <= 1'b0;
            ac_ready_o    <= 1'b1;
            cr_valid_o    <= 1'b0;
            cr_resp_o     <= '0;
            cd_valid_o    <= 1'b0;
            cd_data_o     <= '0;
            cd_last_o     <= 1'b0;
            lkp_req_o     <= 1'b0;
            lkp_addr_o    <= '0;
            lkp_op_o      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ac_valid_i && ac_ready_o) begin
                        snoop_q       <= ac_snoop_i;
                        prot_unused_q <= ac_prot_i;
                        ac_ready_o    <= 1'b0;
                        case (classify_snoop(ac_snoop_i))
                            CLASS_LOOKUP: begin
                                state_q    <= LOOKUP;
                                lkp_req_o  <= 1'b1;
                                lkp_addr_o <= {ac_addr_i[AddrWidth-1:OffsetBits], OffsetBits'(0)};
                                lkp_op_o   <= lookup_op(ac_snoop_i);
                            end
                            CLASS_DVM: begin
                                state_q    <= RESP;
                                cr_valid_o <= 1'b1;
                                cr_resp_o  <= '0;
                                cr_done_q  <= 1'b0;
                                cd_done_q  <= 1'b1;
                            end
                            default: begin
                                state_q    <= RESP;
                                cr_valid_o <= 1'b1;
                                cr_resp_o  <= 5'b00010;
                                cr_done_q  <= 1'b0;
                                cd_done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                LOOKUP: begin
                    if (lkp_gnt_i) begin
                        lkp_req_o <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lkp_valid_i) begin
                        line_q     <= lkp_data_i;
                        cr_resp_o  <= wait_resp;
                        cr_valid_o <= 1'b1;
                        cr_done_q  <= 1'b0;
                        cd_valid_o <= wait_resp.data_transfer;
                        cd_done_q  <= ~wait_resp.data_transfer;
                        cd_data_o  <= lkp_data_i[DataWidth-1:0];
                        cd_last_o  <= wait_resp.data_transfer & (NrBeats == 1);
                        beat_q     <= '0;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (cr_hs) begin
                        cr_valid_o <= 1'b0;
                        cr_done_q  <= 1'b1;
                    end
                    if (cd_hs) begin
                        if (cd_last_o) begin
                            cd_valid_o <= 1'b0;
                            cd_last_o  <= 1'b0;
                            cd_done_q  <= 1'b1;
                        end else begin
                            beat_q    <= beat_next;
                            cd_data_o <= next_beat_data;
                            cd_last_o <= (beat_next == LastBeat);
                        end
                    end
                    if (cr_done_now && cd_done_now) begin
                        state_q    <= IDLE;
                        ac_ready_o <= 1'b1;
                        cr_resp_o  <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ace_snoop_responder.md
Name: ace_snoop_responder

Overview:
- Slave end of the ACE snoop channels (AC request, CR response, CD data) for one core's private data cache.
- Accepts one snoop at a time from the interconnect, performs a single lookup/update transaction on the cache snoop port, then returns the CR response.
- When data transfer is required, it also streams the full cache line on CD.
- Complements the initiator-side ACE AW/AR snoop fields already carried on the core's AXI request.

Parameters:
AddrWidth, 64, snoop address width
DataWidth, 64, CD beat width
LineWidth, 128, cache line width; NrBeats = LineWidth/DataWidth (must be an integer ≥1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ac_valid_i  in  1  snoop request valid
ac_ready_o  out  1  snoop request ready
ac_addr_i  in  AddrWidth  snoop address
ac_snoop_i  in  4  ace_pkg::acsnoop_t
ac_prot_i  in  3  protection (registered, unused)
cr_valid_o  out  1  response valid
cr_ready_i  in  1  response ready
cr_resp_o  out  5  {WasUnique,IsShared,PassDirty,Error,DataTransfer}
cd_valid_o  out  1  data beat valid
cd_ready_i  in  1  data beat ready
cd_data_o  out  DataWidth  data beat
cd_last_o  out  1  last beat
lkp_req_o  out  1  cache lookup request
lkp_gnt_i  in  1  cache grant
lkp_addr_o  out  AddrWidth  line-aligned address
lkp_op_o  out  2  snoop_op_t action applied on hit
lkp_valid_i  in  1  lookup result valid (≥1 cycle after grant)
lkp_hit_i, lkp_dirty_i, lkp_shared_i  in  1 each  line state before the op
lkp_data_i  in  LineWidth  line data

Behaviour:
- Reset: FSM=IDLE, ac_ready_o=1, all other outputs 0. Asynchronous reset mid-transaction aborts it; no CR/CD is resumed.
- FSM states: IDLE, LOOKUP, WAIT, RESP.
- IDLE:
  - ac_ready_o=1. On ac handshake, register addr/snoop/prot and decode.
  - DVM (111x): go to RESP directly with resp=0.
  - Reserved encodings: go to RESP directly with Error=1, no lookup.
  - Otherwise: go to LOOKUP.
- ac_ready_o is 0 in every state except IDLE.
- LOOKUP: lkp_req_o=1, lkp_addr_o = addr with low log2(LineWidth/8) bits zeroed, lkp_op_o from the decode table. Hold until lkp_gnt_i, then go to WAIT.
- WAIT: on lkp_valid_i, register hit/dirty/shared/data, compute resp, go to RESP.
- Decode table (op; response on hit; miss → resp=0, DT=0):
  - ReadOnce 0000: KEEP; DT=1, IS=1, PD=0.
  - ReadShared 0001, ReadClean 0010, ReadNotSharedDirty 0011: SHARE (clear dirty, set shared); DT=1, IS=1, PD=dirty.
  - ReadUnique 0111: INVAL; DT=1, IS=0, PD=dirty.
  - CleanShared 1000: CLEAN; DT=dirty, PD=dirty, IS=1.
  - CleanInvalid 1001: INVAL; DT=dirty, PD=dirty, IS=0.
  - MakeInvalid 1101: INVAL; DT=0, PD=0, IS=0.
  - WasUnique = hit & ~shared for all lookups.
- RESP:
  - cr_valid_o=1 until cr handshake.
  - If DT=1, CD beats are driven in parallel with CR: beat k = line[k*DataWidth +: DataWidth], k=0..NrBeats-1 ascending.
  - A beat counter advances only on cd_valid_o&cd_ready_i. cd_last_o=1 on beat NrBeats-1.
  - CR and CD complete independently, in either order or in the same cycle. Return to IDLE in the cycle after both are done (CD counts as done immediately when DT=0).
- All channel outputs are registered and stable while valid & ~ready. Valids never drop without a handshake.
- Minimum latency with a grant the same cycle and lkp_valid_i one cycle later: ac handshake at t0, lkp_req_o at t1, WAIT at t2, cr_valid_o and the first cd_valid_o at t3.

Decomposition:
- Add to culsans_pkg:
  - snoop_op_t enum {KEEP, SHARE, CLEAN, INVAL}
  - cr_resp_t packed struct with the five bits in port order
  - constants for acsnoop encodings not already in ace_pkg
- No sub-module; the CD beat serializer is an internal counter plus a mux.

Test Plan:
1. ReadShared on a hit, dirty=1, line=128'hBBBB_..._AAAA → lkp_op_o=SHARE; cr_resp_o=5'b01101; two CD beats with low 64 bits first, cd_last_o on beat 2.
2. ReadUnique on a miss → lkp_op_o=INVAL, cr_resp_o=0, cd_valid_o never asserted, ac_ready_o back to 1 the cycle after the CR handshake.
3. CleanInvalid on a clean, non-shared hit → cr_resp_o=5'b10000, no CD; CleanInvalid on a dirty hit → 5'b10101 plus 2 beats.
4. DVM (1111) and reserved (0100) → no lkp_req_o; cr_resp_o=0 and 5'b00010 respectively.
5. Backpressure: cr_ready_i low for 5 cycles, cd_ready_i toggled randomly → outputs stable while stalled, exactly 2 beats, single return to IDLE; also cover CR and last CD completing in the same cycle.
6. Assert rst_ni low during WAIT and during RESP beat 1 → all valids 0 asynchronously; after release ac_ready_o=1 and a new ReadOnce completes normally.
